// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    ACK,
    STOP
  } state_t;

  localparam logic [7:0] CMD_INC  = 8'h01;
  localparam logic [7:0] CMD_DEC  = 8'h02;
  localparam logic       RW_WRITE = 1'b0;

  localparam int QUARTERS_FULL  = 80;
  localparam int QUARTERS_ANACK = 44;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, RW_WRITE};
  endfunction

endpackage

// File: rtl/i2c_cmd_master_if.sv
// Requester handshake and I2C pin bundle between the sequencer and its environment.
interface i2c_cmd_master_if;
  logic       req_inc;
  logic       req_dec;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    input  req_inc, req_dec, sda_i,
    output gnt, busy, done, nack, scl, sda_oe
  );

  modport slave (
    output req_inc, req_dec, sda_i,
    input  gnt, busy, done, nack, scl, sda_oe
  );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-period divider: one tick every CLK_DIV cycles plus a 2-bit quarter index.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Held at zero while disabled so every transaction starts on a fresh q0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (!enable) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (tick) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_master.sv
// Single-master I2C write sequencer: round-robin arbitration of inc/dec requests,
// then START, address+W, ACK, command byte, ACK, STOP.
module i2c_cmd_master
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 250,
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic             clk,
  input  logic             reset,
  i2c_cmd_master_if.master bus
);

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic       byte_q, byte_d;          // 0: address byte, 1: command byte
  logic [7:0] cmd_q, cmd_d;
  logic       prefer_dec_q, prefer_dec_d;
  logic       nack_q, nack_d;

  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic [1:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       nack_out_q, nack_out_d;

  logic       sda_meta, sda_sync;
  logic       tick;
  logic [1:0] quarter, quarter_d;
  logic       step_end;
  logic       grant_dec;
  logic [7:0] tx_byte;
  logic       tx_bit;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_q != IDLE),
    .tick    (tick),
    .quarter (quarter)
  );

  assign step_end  = tick && (quarter == 2'd3);
  assign quarter_d = tick ? quarter + 2'd1 : quarter;

  // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    cmd_d        = cmd_q;
    prefer_dec_d = prefer_dec_q;
    nack_d       = nack_q;
    gnt_d        = 2'b00;
    done_d       = 1'b0;
    nack_out_d   = 1'b0;
    grant_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_inc || bus.req_dec) begin
          grant_dec    = bus.req_dec && (!bus.req_inc || prefer_dec_q);
          gnt_d        = grant_dec ? 2'b10 : 2'b01;
          cmd_d        = grant_dec ? CMD_DEC : CMD_INC;
          prefer_dec_d = !grant_dec;
          nack_d       = 1'b0;
          byte_d       = 1'b0;
          bit_d        = 3'd7;
          state_d      = START;
        end
      end
      START: begin
        if (step_end) state_d = SHIFT;
      end
      SHIFT: begin
        if (step_end) begin
          if (bit_q == 3'd0) state_d = ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      ACK: begin
        if (tick && (quarter == 2'd1 + 2'd1) && sda_sync) nack_d = 1'b1;
        // An address NACK skips the command byte entirely.
        if (step_end) begin
          if (!byte_q && !nack_q) begin
            state_d = SHIFT;
            byte_d  = 1'b1;
            bit_d   = 3'd7;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (step_end) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          nack_out_d = nack_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are derived from the upcoming state/quarter so the registered pins line up with it.
  always_comb begin
    tx_byte  = byte_d ? cmd_d : addr_byte(SLAVE_ADDR);
    tx_bit   = tx_byte[bit_d];
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    busy_d   = (state_d != IDLE);

    case (state_d)
      START: begin
        scl_d    = 1'b1;
        sda_oe_d = quarter_d[1];
      end
      SHIFT: begin
        scl_d    = quarter_d[1];
        sda_oe_d = !tx_bit;
      end
      ACK: begin
        scl_d    = quarter_d[1];
        sda_oe_d = 1'b0;
      end
      STOP: begin
        scl_d    = quarter_d[1];
        sda_oe_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_q        <= 3'd7;
      byte_q       <= 1'b0;
      cmd_q        <= CMD_INC;
      prefer_dec_q <= 1'b0;
      nack_q       <= 1'b0;
      scl_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      gnt_q        <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nack_out_q   <= 1'b0;
      sda_meta     <= 1'b1;
      sda_sync     <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      cmd_q        <= cmd_d;
      prefer_dec_q <= prefer_dec_d;
      nack_q       <= nack_d;
      scl_q        <= scl_d;
      sda_oe_q     <= sda_oe_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nack_out_q   <= nack_out_d;
      sda_meta     <= bus.sda_i;
      sda_sync     <= sda_meta;
    end
  end

  assign bus.scl    = scl_q;
  assign bus.sda_oe = sda_oe_q;
  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.nack   = nack_out_q;

endmodule
